ifu: RTL



---
 rtl/ifu.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: turns single-word fetch requests into
// OCP-style read transactions with alignment, bus-error and timeout handling.
module ifu #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_addr,
   input  logic        i_rd_cmd,
   output logic [31:0] o_instr_dat,
   output logic        o_busy,
   output logic        o_err_align,
   output logic        o_err_bus,
   output logic [31:0] o_MAddr,
   output logic [2:0]  o_MCmd,
   output logic [3:0]  o_MByteEn,
   input  logic        i_SCmdAccept,
   input  logic [31:0] i_SData,
   input  logic [1:0]  i_SResp
);

   localparam logic [2:0] MCMD_IDLE = 3'b000;
   localparam logic [2:0] MCMD_READ = 3'b010;
   localparam logic [1:0] SRESP_DVA = 2'b01;
   localparam logic [1:0] SRESP_ERR = 2'b11;

   localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_RESP
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic        err_align_q, err_align_d;
   logic        err_bus_q, err_bus_d;
   logic [15:0] cnt_q, cnt_d;

   logic aligned;
   logic timeout;

   assign aligned = (i_addr[1:0] == 2'b00);
   // Only meaningful while in CMD or RESP; the counter is cleared on entry.
   assign timeout = TO_EN && (cnt_q == TO_LAST);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      instr_d     = instr_q;
      err_align_d = 1'b0;
      err_bus_d   = 1'b0;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (i_rd_cmd) begin
               if (aligned) begin
                  addr_d  = {i_addr[31:2], 2'b00};
                  state_d = S_CMD;
               end else begin
                  err_align_d = 1'b1;
                  instr_d     = '0;
               end
            end
         end
         S_CMD: begin
            cnt_d = cnt_q + 16'd1;
            if (timeout) begin
               err_bus_d = 1'b1;
               instr_d   = '0;
               state_d   = S_IDLE;
            end else if (i_SCmdAccept) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            cnt_d = cnt_q + 16'd1;
            // A real response beats a timeout landing in the same cycle.
            if (i_SResp == SRESP_DVA) begin
               instr_d = i_SData;
               state_d = S_IDLE;
            end else if (i_SResp == SRESP_ERR) begin
               instr_d   = '0;
               err_bus_d = 1'b1;
               state_d   = S_IDLE;
            end else if (timeout) begin
               instr_d   = '0;
               err_bus_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         instr_q     <= '0;
         err_align_q <= 1'b0;
         err_bus_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         instr_q     <= instr_d;
         err_align_q <= err_align_d;
         err_bus_q   <= err_bus_d;
         cnt_q       <= cnt_d;
      end
   end

   assign o_busy      = (state_q != S_IDLE) | (i_rd_cmd & aligned);
   assign o_instr_dat = instr_q;
   assign o_err_align = err_align_q;
   assign o_err_bus   = err_bus_q;
   assign o_MAddr     = addr_q;
   assign o_MCmd      = (state_q == S_CMD) ? MCMD_READ : MCMD_IDLE;
   assign o_MByteEn   = (state_q == S_CMD) ? 4'hF : 4'h0;

endmodule
